// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared forwarding select codes and hazard controller state encodings.
package forwarding_hazard_unit_pkg;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_STALL = 1'b1
   } state_t;

endpackage

// File: rtl/forwarding_hazard_unit_forward_select.sv
// One operand forwarding mux: MEM result beats WB result beats register file; r0 never forwards.
// Purely combinational, zero latency, no flow control.
module forward_select
   import forwarding_hazard_unit_pkg::*;
#(
   parameter int NBITS   = 32,
   parameter int REGBITS = 5
) (
   input  logic [REGBITS-1:0] i_src,
   input  logic               i_mem_regwrite,
   input  logic [REGBITS-1:0] i_mem_dest,
   input  logic [NBITS-1:0]   i_mem_data,
   input  logic               i_wb_regwrite,
   input  logic [REGBITS-1:0] i_wb_dest,
   input  logic [NBITS-1:0]   i_wb_data,
   input  logic [NBITS-1:0]   i_reg_data,
   output logic [NBITS-1:0]   o_data,
   output logic [1:0]         o_sel
);

   logic w_mem_hit;
   logic w_wb_hit;

   assign w_mem_hit = i_mem_regwrite && (i_mem_dest != '0) && (i_mem_dest == i_src);
   assign w_wb_hit  = i_wb_regwrite  && (i_wb_dest  != '0) && (i_wb_dest  == i_src);

   always_comb begin
      o_data = i_reg_data;
      o_sel  = FWD_REG;
      if (w_mem_hit) begin
         o_data = i_mem_data;
         o_sel  = FWD_MEM;
      end else if (w_wb_hit) begin
         o_data = i_wb_data;
         o_sel  = FWD_WB;
      end
   end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// EX operand/store-data forwarding plus load-use stall controller with hold and flush.
// Forwarding is combinational; stalls last LOAD_STALL_CYCLES bubbles; i_hold freezes, i_flush aborts.
module forwarding_hazard_unit
   import forwarding_hazard_unit_pkg::*;
#(
   parameter int NBITS             = 32,
   parameter int REGBITS           = 5,
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int CNTBITS           = 16
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_hold,
   input  logic               i_flush,
   input  logic [REGBITS-1:0] i_ID_rs,
   input  logic [REGBITS-1:0] i_ID_rt,
   input  logic               i_ID_uses_rs,
   input  logic               i_ID_uses_rt,
   input  logic [REGBITS-1:0] i_EX_rs,
   input  logic [REGBITS-1:0] i_EX_rt,
   input  logic               i_EX_MemRead,
   input  logic [REGBITS-1:0] i_EX_dest,
   input  logic               i_EX_ALUSrc,
   input  logic [NBITS-1:0]   i_EX_RegA,
   input  logic [NBITS-1:0]   i_EX_RegB,
   input  logic [NBITS-1:0]   i_EX_ExtensionData,
   input  logic               i_MEM_RegWrite,
   input  logic [REGBITS-1:0] i_MEM_dest,
   input  logic [NBITS-1:0]   i_MEM_Operando,
   input  logic               i_WB_RegWrite,
   input  logic [REGBITS-1:0] i_WB_dest,
   input  logic [NBITS-1:0]   i_WB_Operando,
   output logic [NBITS-1:0]   o_ALU_A,
   output logic [NBITS-1:0]   o_ALU_B,
   output logic [NBITS-1:0]   o_StoreData,
   output logic [1:0]         o_fwd_sel_A,
   output logic [1:0]         o_fwd_sel_B,
   output logic               o_pc_write,
   output logic               o_ifid_write,
   output logic               o_idex_flush,
   output logic [CNTBITS-1:0] o_stall_count
);

   localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);

   state_t             r_state;
   state_t             w_next_state;
   logic [2:0]         r_cnt;
   logic [2:0]         w_next_cnt;
   logic [CNTBITS-1:0] r_stall_count;
   logic               w_hazard;
   logic               w_stall_now;
   logic [NBITS-1:0]   w_fwd_rs;
   logic [NBITS-1:0]   w_fwd_rt;

   forward_select #(.NBITS(NBITS), .REGBITS(REGBITS)) u_fwd_rs (
      .i_src(i_EX_rs), .i_mem_regwrite(i_MEM_RegWrite), .i_mem_dest(i_MEM_dest),
      .i_mem_data(i_MEM_Operando), .i_wb_regwrite(i_WB_RegWrite), .i_wb_dest(i_WB_dest),
      .i_wb_data(i_WB_Operando), .i_reg_data(i_EX_RegA), .o_data(w_fwd_rs), .o_sel(o_fwd_sel_A)
   );

   forward_select #(.NBITS(NBITS), .REGBITS(REGBITS)) u_fwd_rt (
      .i_src(i_EX_rt), .i_mem_regwrite(i_MEM_RegWrite), .i_mem_dest(i_MEM_dest),
      .i_mem_data(i_MEM_Operando), .i_wb_regwrite(i_WB_RegWrite), .i_wb_dest(i_WB_dest),
      .i_wb_data(i_WB_Operando), .i_reg_data(i_EX_RegB), .o_data(w_fwd_rt), .o_sel(o_fwd_sel_B)
   );

   assign o_ALU_A       = w_fwd_rs;
   assign o_ALU_B       = i_EX_ALUSrc ? i_EX_ExtensionData : w_fwd_rt;
   assign o_StoreData   = w_fwd_rt;
   assign o_stall_count = r_stall_count;

   assign w_hazard = i_EX_MemRead && (i_EX_dest != '0) &&
                     ((i_ID_uses_rs && (i_ID_rs == i_EX_dest)) ||
                      (i_ID_uses_rt && (i_ID_rt == i_EX_dest)));

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_stall_count <= '0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
         if (w_stall_now && (r_stall_count != {CNTBITS{1'b1}}))
            r_stall_count <= r_stall_count + 1'b1;
      end
   end

   // Flush beats hold, hold beats any stall activity.
   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      w_stall_now  = 1'b0;
      if (i_flush) begin
         w_next_state = ST_IDLE;
         w_next_cnt   = '0;
      end else if (!i_hold) begin
         case (r_state)
            ST_IDLE: begin
               if (w_hazard) begin
                  w_stall_now = 1'b1;
                  if (LOAD_STALL_CYCLES > 1) begin
                     w_next_state = ST_STALL;
                     w_next_cnt   = STALL_RELOAD;
                  end
               end
            end
            ST_STALL: begin
               w_stall_now = 1'b1;
               w_next_cnt  = r_cnt - 3'd1;
               if (r_cnt == 3'd1)
                  w_next_state = ST_IDLE;
            end
            default: begin
               w_next_state = ST_IDLE;
               w_next_cnt   = '0;
            end
         endcase
      end
   end

   always_comb begin
      o_pc_write   = 1'b1;
      o_ifid_write = 1'b1;
      o_idex_flush = 1'b0;
      if (!i_reset) begin
         if (i_flush) begin
            o_ifid_write = 1'b0;
            o_idex_flush = 1'b1;
         end else if (i_hold) begin
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
         end else if (w_stall_now) begin
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
            o_idex_flush = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench: u1 has a single-bubble stall, u3 has three bubbles and a 2-bit saturating counter.
module tb_forwarding_hazard_unit;

   localparam logic [31:0] REGA = 32'h1000_0001;
   localparam logic [31:0] REGB = 32'h2000_0002;
   localparam logic [31:0] IMM  = 32'h0000_0004;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] st;
      logic [1:0]  sa;
      logic [1:0]  sb;
      logic [2:0]  c1;
      logic [15:0] n1;
      logic [2:0]  c3;
      logic [1:0]  n3;
   } exp_t;

   logic clk = 1'b1;
   logic rst, hold, flush;
   logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_dest, mem_dest, wb_dest;
   logic id_urs, id_urt, ex_rd, alusrc, mem_we, wb_we;
   logic [31:0] mem_val, wb_val;

   logic [31:0] a1, b1, s1, a3, b3, s3;
   logic [1:0]  sa1, sb1, sa3, sb3;
   logic        pc1, if1, fl1, pc3, if3, fl3;
   logic [15:0] n1;
   logic [1:0]  n3;

   exp_t  exp_q[$];
   string name_q[$];
   int    vectors = 0;
   int    miscompares = 0;

   always #5 clk = ~clk;

   forwarding_hazard_unit #(.NBITS(32), .REGBITS(5), .LOAD_STALL_CYCLES(1), .CNTBITS(16)) u1 (
      .i_clk(clk), .i_reset(rst), .i_hold(hold), .i_flush(flush),
      .i_ID_rs(id_rs), .i_ID_rt(id_rt), .i_ID_uses_rs(id_urs), .i_ID_uses_rt(id_urt),
      .i_EX_rs(ex_rs), .i_EX_rt(ex_rt), .i_EX_MemRead(ex_rd), .i_EX_dest(ex_dest),
      .i_EX_ALUSrc(alusrc), .i_EX_RegA(REGA), .i_EX_RegB(REGB), .i_EX_ExtensionData(IMM),
      .i_MEM_RegWrite(mem_we), .i_MEM_dest(mem_dest), .i_MEM_Operando(mem_val),
      .i_WB_RegWrite(wb_we), .i_WB_dest(wb_dest), .i_WB_Operando(wb_val),
      .o_ALU_A(a1), .o_ALU_B(b1), .o_StoreData(s1), .o_fwd_sel_A(sa1), .o_fwd_sel_B(sb1),
      .o_pc_write(pc1), .o_ifid_write(if1), .o_idex_flush(fl1), .o_stall_count(n1)
   );

   forwarding_hazard_unit #(.NBITS(32), .REGBITS(5), .LOAD_STALL_CYCLES(3), .CNTBITS(2)) u3 (
      .i_clk(clk), .i_reset(rst), .i_hold(hold), .i_flush(flush),
      .i_ID_rs(id_rs), .i_ID_rt(id_rt), .i_ID_uses_rs(id_urs), .i_ID_uses_rt(id_urt),
      .i_EX_rs(ex_rs), .i_EX_rt(ex_rt), .i_EX_MemRead(ex_rd), .i_EX_dest(ex_dest),
      .i_EX_ALUSrc(alusrc), .i_EX_RegA(REGA), .i_EX_RegB(REGB), .i_EX_ExtensionData(IMM),
      .i_MEM_RegWrite(mem_we), .i_MEM_dest(mem_dest), .i_MEM_Operando(mem_val),
      .i_WB_RegWrite(wb_we), .i_WB_dest(wb_dest), .i_WB_Operando(wb_val),
      .o_ALU_A(a3), .o_ALU_B(b3), .o_StoreData(s3), .o_fwd_sel_A(sa3), .o_fwd_sel_B(sb3),
      .o_pc_write(pc3), .o_ifid_write(if3), .o_idex_flush(fl3), .o_stall_count(n3)
   );

   task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, req);
      end
   endtask

   // Monitor: every cycle with a pending expectation is checked on the falling edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t  e;
         string nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         vectors++;
         chk(nm, "u1_alu_a", a1, e.a);   chk(nm, "u3_alu_a", a3, e.a);
         chk(nm, "u1_alu_b", b1, e.b);   chk(nm, "u3_alu_b", b3, e.b);
         chk(nm, "u1_store", s1, e.st);  chk(nm, "u3_store", s3, e.st);
         chk(nm, "u1_sel_a", {30'd0, sa1}, {30'd0, e.sa});
         chk(nm, "u1_sel_b", {30'd0, sb1}, {30'd0, e.sb});
         chk(nm, "u3_sel_a", {30'd0, sa3}, {30'd0, e.sa});
         chk(nm, "u3_sel_b", {30'd0, sb3}, {30'd0, e.sb});
         chk(nm, "u1_pc_ifid_flush", {29'd0, pc1, if1, fl1}, {29'd0, e.c1});
         chk(nm, "u3_pc_ifid_flush", {29'd0, pc3, if3, fl3}, {29'd0, e.c3});
         chk(nm, "u1_stall_count", {16'd0, n1}, {16'd0, e.n1});
         chk(nm, "u3_stall_count", {30'd0, n3}, {30'd0, e.n3});
      end
   end

   task automatic fwd(input logic mw, input logic [4:0] md, input logic [31:0] mv,
                      input logic ww, input logic [4:0] wd, input logic [31:0] wv,
                      input logic [4:0] rs, input logic [4:0] rt, input logic src);
      mem_we = mw; mem_dest = md; mem_val = mv;
      wb_we = ww; wb_dest = wd; wb_val = wv;
      ex_rs = rs; ex_rt = rt; alusrc = src;
   endtask

   task automatic haz(input logic rd, input logic [4:0] dst, input logic [4:0] irs,
                      input logic urs, input logic [4:0] irt, input logic urt);
      ex_rd = rd; ex_dest = dst; id_rs = irs; id_urs = urs; id_rt = irt; id_urt = urt;
   endtask

   task automatic ctl(input logic r, input logic h, input logic f);
      rst = r; hold = h; flush = f;
   endtask

   task automatic vec(input string nm, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] st, input logic [1:0] sa, input logic [1:0] sb,
                      input logic [2:0] c1, input logic [15:0] nn1,
                      input logic [2:0] c3, input logic [1:0] nn3);
      exp_t e;
      e = '{a: a, b: b, st: st, sa: sa, sb: sb, c1: c1, n1: nn1, c3: c3, n3: nn3};
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   task automatic vf(input string nm, input logic [2:0] c1, input logic [15:0] nn1,
                     input logic [2:0] c3, input logic [1:0] nn3);
      vec(nm, REGA, REGB, REGB, 2'b00, 2'b00, c1, nn1, c3, nn3);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, %0d vectors checked", vectors);
      $fatal(1);
   end

   // Control columns are {pc_write, ifid_write, idex_flush}.
   initial begin
      ctl(1, 0, 0);
      fwd(0, 0, 0, 0, 0, 0, 1, 2, 0);
      haz(0, 0, 0, 0, 0, 0);
      vf("reset", 3'b110, 0, 3'b110, 0);

      ctl(0, 0, 0);
      fwd(1, 3, 32'h11, 1, 3, 32'h22, 3, 2, 0);
      vec("rs_mem_over_wb", 32'h11, REGB, REGB, 2'b01, 2'b00, 3'b110, 0, 3'b110, 0);
      fwd(0, 3, 32'h11, 1, 3, 32'h22, 3, 2, 0);
      vec("rs_wb_only", 32'h22, REGB, REGB, 2'b10, 2'b00, 3'b110, 0, 3'b110, 0);
      fwd(1, 3, 32'h11, 1, 3, 32'h22, 1, 3, 0);
      vec("rt_mem", REGA, 32'h11, 32'h11, 2'b00, 2'b01, 3'b110, 0, 3'b110, 0);
      fwd(1, 0, 32'hFF, 1, 0, 32'hEE, 1, 0, 0);
      vec("r0_no_fwd", REGA, REGB, REGB, 2'b00, 2'b00, 3'b110, 0, 3'b110, 0);
      fwd(1, 3, 32'h11, 0, 3, 32'h22, 1, 3, 1);
      vec("alusrc_imm", REGA, IMM, 32'h11, 2'b00, 2'b01, 3'b110, 0, 3'b110, 0);
      fwd(1, 5, 32'h11, 1, 2, 32'h22, 5, 2, 0);
      vec("rs_mem_rt_wb", 32'h11, 32'h22, 32'h22, 2'b01, 2'b10, 3'b110, 0, 3'b110, 0);

      fwd(0, 0, 0, 0, 0, 0, 1, 2, 0);
      haz(1, 5, 5, 1, 0, 0);
      vf("loaduse_first", 3'b001, 0, 3'b001, 0);
      haz(0, 0, 0, 0, 0, 0);
      vf("loaduse_second", 3'b110, 1, 3'b001, 1);
      ctl(0, 1, 0);
      vf("hold_in_stall_1", 3'b000, 1, 3'b000, 2);
      vf("hold_in_stall_2", 3'b000, 1, 3'b000, 2);
      ctl(0, 0, 0);
      vf("stall_resume", 3'b110, 1, 3'b001, 2);
      vf("stall_done", 3'b110, 1, 3'b110, 3);
      haz(1, 5, 5, 0, 5, 0);
      vf("no_use_no_hazard", 3'b110, 1, 3'b110, 3);
      haz(1, 5, 0, 0, 5, 1);
      vf("rt_hazard", 3'b001, 1, 3'b001, 3);
      haz(0, 0, 0, 0, 0, 0);
      ctl(0, 0, 1);
      vf("flush_in_stall", 3'b101, 2, 3'b101, 3);
      ctl(0, 0, 0);
      vf("after_flush_idle", 3'b110, 2, 3'b110, 3);
      haz(1, 0, 0, 1, 0, 0);
      vf("load_to_r0", 3'b110, 2, 3'b110, 3);
      haz(1, 5, 5, 1, 0, 0);
      ctl(0, 1, 1);
      vf("flush_beats_hold", 3'b101, 2, 3'b101, 3);
      ctl(0, 1, 0);
      vf("hold_beats_hazard", 3'b000, 2, 3'b000, 3);
      ctl(0, 0, 0);
      vf("hazard_saturate", 3'b001, 2, 3'b001, 3);
      ctl(1, 0, 0);
      vf("reset_mid_stall", 3'b110, 0, 3'b110, 0);
      ctl(0, 0, 0);
      haz(0, 0, 0, 0, 0, 0);
      vf("post_reset_idle", 3'b110, 0, 3'b110, 0);

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
